// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory (fill and writeback).
// Optional CACHELINE_ADAPTOR_EARLY_RESP_EN: read completion in the final-beat cycle.
module cacheline_adaptor #(
  parameter int unsigned s_line      = 256,
  parameter int unsigned burst_width = 64,
  parameter int unsigned addr_width  = 32,
  parameter int unsigned s_offset    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [s_line-1:0]      line_i,
  output logic [s_line-1:0]      line_o,
  input  logic [addr_width-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [burst_width-1:0] burst_i,
  output logic [burst_width-1:0] burst_o,
  output logic [addr_width-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int unsigned num_beats = s_line / burst_width;
  localparam int unsigned beat_w    = $clog2(num_beats);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state, state_next;
  logic [beat_w-1:0]   beat;
  logic [s_line-1:0]   line_q;
  logic [s_line-1:0]   wbuf;
  logic                last_beat;

  assign last_beat = (beat == beat_w'(num_beats - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    line_o     = line_q;
    case (state)
      IDLE: begin
        if (write_i)     state_next = WRITE;
        else if (read_i) state_next = READ;
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i && last_beat) begin
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
          // Final beat bypasses the register so completion lands this cycle.
          resp_o                                 = 1'b1;
          line_o[s_line-1 -: burst_width]        = burst_i;
          state_next                             = IDLE;
`else
          state_next = DONE;
`endif
        end
      end
      WRITE: begin
        write_o = 1'b1;
        if (resp_i && last_beat) state_next = DONE;
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat      <= '0;
      line_q    <= '0;
      wbuf      <= '0;
      burst_o   <= '0;
      address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            address_o <= {address_i[addr_width-1:s_offset], {s_offset{1'b0}}};
            beat      <= '0;
          end
          if (write_i) begin
            wbuf    <= line_i;
            burst_o <= line_i[burst_width-1:0];
          end
        end
        READ: begin
          if (resp_i) begin
            for (int unsigned i = 0; i < num_beats; i++)
              if (beat == beat_w'(i)) line_q[i*burst_width +: burst_width] <= burst_i;
            beat <= beat + beat_w'(1);
          end
        end
        WRITE: begin
          if (resp_i) begin
            // burst_o is preloaded with the following slice so it is valid with write_o.
            if (!last_beat)
              for (int unsigned i = 0; i < num_beats; i++)
                if (beat + beat_w'(1) == beat_w'(i)) burst_o <= wbuf[i*burst_width +: burst_width];
            beat <= beat + beat_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: transaction-level model of fills and writebacks.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  int vectors = 0;
  int miscompares = 0;
  logic [255:0] exp_line = '0;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_read(input logic [31:0] addr, input bit fixed, input int stall_pct);
    logic [63:0] q[$];
    logic [63:0] b;
    logic [31:0] exp_addr;
    bit r;
    int cyc;
    exp_addr = addr & 32'hFFFF_FFE0;
    read_i = 1'b1; write_i = 1'b0; address_i = addr;
    resp_i = 1'($urandom_range(1)); burst_i = {$urandom, $urandom};
    tick();
    address_i = $urandom;
    cyc = 0;
    while (q.size() < 4 && cyc < 64) begin
      r = fixed ? 1'b1 : ($urandom_range(99) >= stall_pct);
      b = fixed ? 64'h1111_1111_1111_1111 * (q.size() + 1) : {$urandom, $urandom};
      resp_i = r; burst_i = b;
      #1;
      vectors++;
      if (read_o !== 1'b1 || write_o !== 1'b0) begin
        miscompares++; $display("FAIL rd_req: read_o=%b write_o=%b required 1/0", read_o, write_o);
      end
      vectors++;
      if (address_o !== exp_addr) begin
        miscompares++; $display("FAIL rd_addr: got %h required %h", address_o, exp_addr);
      end
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
      if (r && q.size() == 3) begin
        vectors++;
        if (resp_o !== 1'b1) begin
          miscompares++; $display("FAIL rd_early_resp: got %b required 1", resp_o);
        end
        vectors++;
        if (line_o[255:192] !== b) begin
          miscompares++; $display("FAIL rd_early_top: got %h required %h", line_o[255:192], b);
        end
        read_i = 1'b0;
      end else begin
        vectors++;
        if (resp_o !== 1'b0) begin
          miscompares++; $display("FAIL rd_resp_early: got %b required 0", resp_o);
        end
      end
`else
      vectors++;
      if (resp_o !== 1'b0) begin
        miscompares++; $display("FAIL rd_resp_early: got %b required 0", resp_o);
      end
`endif
      if (r) q.push_back(b);
      tick();
      cyc++;
    end
    vectors++;
    if (q.size() != 4) begin
      miscompares++; $display("FAIL rd_timeout: beats %0d required 4", q.size());
      read_i = 1'b0;
      return;
    end
    exp_line = {q[3], q[2], q[1], q[0]};
    if (fixed) begin
      vectors++;
      if (cyc != 4) begin
        miscompares++; $display("FAIL rd_latency: read_o cycles %0d required 4", cyc);
      end
    end
`ifndef CACHELINE_ADAPTOR_EARLY_RESP_EN
    resp_i = 1'($urandom_range(1)); burst_i = {$urandom, $urandom};
    #1;
    vectors++;
    if (resp_o !== 1'b1 || read_o !== 1'b0) begin
      miscompares++; $display("FAIL rd_done: resp_o=%b read_o=%b required 1/0", resp_o, read_o);
    end
    vectors++;
    if (line_o !== exp_line) begin
      miscompares++; $display("FAIL rd_line: got %h required %h", line_o, exp_line);
    end
    read_i = 1'b0;
    tick();
`endif
    resp_i = 1'($urandom_range(1));
    #1;
    vectors++;
    if (resp_o !== 1'b0 || read_o !== 1'b0) begin
      miscompares++; $display("FAIL rd_after: resp_o=%b read_o=%b required 0/0", resp_o, read_o);
    end
    vectors++;
    if (line_o !== exp_line) begin
      miscompares++; $display("FAIL rd_line_hold: got %h required %h", line_o, exp_line);
    end
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [255:0] line, input bit use_pat,
                           input logic [31:0] pat, input int stall_pct, input bit also_read);
    logic [31:0] exp_addr;
    bit r;
    int cyc, k;
    exp_addr = addr & 32'hFFFF_FFE0;
    write_i = 1'b1; read_i = also_read; address_i = addr; line_i = line;
    resp_i = 1'($urandom_range(1)); burst_i = {$urandom, $urandom};
    tick();
    line_i = {8{$urandom}}; address_i = $urandom;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 64) begin
      r = use_pat ? pat[cyc % 32] : ($urandom_range(99) >= stall_pct);
      resp_i = r; burst_i = {$urandom, $urandom};
      #1;
      vectors++;
      if (write_o !== 1'b1 || read_o !== 1'b0 || resp_o !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_req: write_o=%b read_o=%b resp_o=%b required 1/0/0", write_o, read_o, resp_o);
      end
      vectors++;
      if (address_o !== exp_addr) begin
        miscompares++; $display("FAIL wr_addr: got %h required %h", address_o, exp_addr);
      end
      vectors++;
      if (burst_o !== line[k*64 +: 64]) begin
        miscompares++; $display("FAIL wr_beat%0d: got %h required %h", k, burst_o, line[k*64 +: 64]);
      end
      if (r) k++;
      tick();
      cyc++;
    end
    vectors++;
    if (k != 4) begin
      miscompares++; $display("FAIL wr_timeout: beats %0d required 4", k);
    end
    if (use_pat) begin
      vectors++;
      if (cyc != 7) begin
        miscompares++; $display("FAIL wr_cycles: got %0d required 7", cyc);
      end
    end
    write_i = 1'b0; resp_i = 1'($urandom_range(1));
    #1;
    vectors++;
    if (resp_o !== 1'b1 || write_o !== 1'b0) begin
      miscompares++; $display("FAIL wr_done: resp_o=%b write_o=%b required 1/0", resp_o, write_o);
    end
    vectors++;
    if (line_o !== exp_line) begin
      miscompares++; $display("FAIL wr_line_o: got %h required %h", line_o, exp_line);
    end
    tick();
    #1;
    vectors++;
    if (resp_o !== 1'b0 || write_o !== 1'b0) begin
      miscompares++; $display("FAIL wr_after: resp_o=%b write_o=%b required 0/0", resp_o, write_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '1; address_i = '1; burst_i = '1;
    tick(); tick();
    vectors++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctl: got %b required 000", {read_o, write_o, resp_o});
    end
    vectors++;
    if (line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
      miscompares++; $display("FAIL reset_data: line_o=%h burst_o=%h address_o=%h required 0", line_o, burst_o, address_o);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read_no_stall();
    run_read(32'h1234_5678, 1'b1, 0);
    vectors++;
    if (exp_line !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111} || line_o !== exp_line) begin
      miscompares++; $display("FAIL rd_fixed_line: got %h", line_o);
    end
    tick();
  endtask

  task automatic test_write_stalls();
    run_write(32'hCAFE_BABF,
              256'h0123456789ABCDEF_1122334455667788_99AABBCCDDEEFF00_FEDCBA9876543210,
              1'b1, 32'h0000_0059, 0, 1'b0);
  endtask

  task automatic test_both_requests();
    logic [255:0] prev;
    prev = exp_line;
    run_write(32'h0000_1040, {8{$urandom}}, 1'b0, '0, 30, 1'b1);
    vectors++;
    if (line_o !== prev) begin
      miscompares++; $display("FAIL both_line_kept: got %h required %h", line_o, prev);
    end
    run_read(32'h0000_2080, 1'b0, 30);
    tick();
  endtask

  task automatic test_spurious_resp();
    for (int i = 0; i < 5; i++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      #1;
      vectors++;
      if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== exp_line) begin
        miscompares++; $display("FAIL idle_spurious: ctl=%b line_o=%h required 000 %h", {read_o, write_o, resp_o}, line_o, exp_line);
      end
      tick();
    end
    run_read($urandom, 1'b0, 40);
    tick();
  endtask

  task automatic test_reset_mid_read();
    read_i = 1'b1; address_i = 32'hABCD_0000; resp_i = 1'b0;
    tick();
    resp_i = 1'b1; burst_i = {$urandom, $urandom}; tick();
    burst_i = {$urandom, $urandom}; tick();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== '0 || burst_o !== '0 || address_o !== '0) begin
      miscompares++; $display("FAIL reset_mid: ctl=%b line_o=%h address_o=%h required all 0", {read_o, write_o, resp_o}, line_o, address_o);
    end
    exp_line = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (resp_o !== 1'b0 || read_o !== 1'b0) begin
        miscompares++; $display("FAIL reset_hold: resp_o=%b read_o=%b required 0/0", resp_o, read_o);
      end
    end
    read_i = 1'b0; resp_i = 1'b0; rst = 1'b1;
    tick();
    vectors++;
    if (resp_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_no_resp: got %b required 0", resp_o);
    end
    run_read(32'h0BAD_F00D, 1'b0, 25);
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(1) == 1) run_write($urandom, {8{$urandom}}, 1'b0, '0, $urandom_range(60), 1'b0);
      else begin
        run_read($urandom, 1'b0, $urandom_range(60));
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_no_stall();
    test_write_stalls();
    test_both_requests();
    test_spurious_resp();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
